// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED PWM peripheral: register map, period, CTRL fields.
// No logic, so no latency.
// No flow control; only a byte-merge helper for masked bus writes.
package led_pwm_pkg;

    // Word offsets, decoded from address bits [3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_DUTY_LO = 2'd1;
    localparam logic [1:0] REG_DUTY_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int         PWM_PERIOD  = 255;
    localparam logic [7:0] PWM_CNT_MAX = 8'(PWM_PERIOD - 1);

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PRESCALE_LSB = 16;
    localparam int CTRL_PRESCALE_MSB = 31;
    localparam int STATUS_WRAP_BIT   = 8;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                 input logic [31:0] wdat,
                                                 input logic [3:0]  mask);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) res[8*b +: 8] = wdat[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler plus 0..254 period counter feeding the LED comparators.
// tick/wrap are combinational from the counter state; counters move 1 edge later.
// No backpressure; enable low holds both counters at zero.
module led_pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [7:0]            pwm_cnt,
    output logic                  tick,
    output logic                  wrap
);

    logic [PRESCALE_W-1:0] presc_cnt;

    // Equality compare: a prescale written below presc_cnt lets the counter
    // run through all-ones and wrap naturally before the next tick.
    assign tick = enable && (presc_cnt == prescale);
    assign wrap = tick && (pwm_cnt == PWM_CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (!enable) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            if (tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESCALE_W'(1);
            end
            if (wrap) begin
                pwm_cnt <= '0;
            end else if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/led_pwm.sv
// 8-channel memory-mapped LED PWM; LED_PWM_SHADOW_EN adds period-aligned duty shadowing.
// Bus is zero-wait (ready = sel, reads combinational); leds_out is 1 register after the compare.
// No backpressure: every selected access completes in the cycle it is presented.
module led_pwm
    import led_pwm_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic [7:0]  leds_out
);

    logic        ctrl_en;
    logic [15:0] ctrl_presc;
    logic [31:0] duty_lo_wr;
    logic [31:0] duty_hi_wr;
    logic [31:0] duty_lo_act;
    logic [31:0] duty_hi_act;
    logic        wrap_seen;

    logic [7:0]  pwm_cnt;
    logic        tick;
    logic        wrap;
    logic [7:0]  leds_next;

    logic [1:0]  reg_sel;
    logic        bus_wr;
    logic        unused_ok;

    assign reg_sel   = address_in[3:2];
    assign bus_wr    = sel_in && (write_mask_in != 4'b0000);
    assign ready_out = sel_in;
    assign unused_ok = ^{address_in[31:4], address_in[1:0], tick};

    led_pwm_timebase #(
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .enable   (ctrl_en),
        .prescale (PRESCALE_W'(ctrl_presc)),
        .pwm_cnt  (pwm_cnt),
        .tick     (tick),
        .wrap     (wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en    <= 1'b0;
            ctrl_presc <= '0;
            duty_lo_wr <= '0;
            duty_hi_wr <= '0;
        end else if (bus_wr) begin
            case (reg_sel)
                REG_CTRL: begin
                    if (write_mask_in[0]) ctrl_en          <= write_value_in[CTRL_EN_BIT];
                    if (write_mask_in[2]) ctrl_presc[7:0]  <= write_value_in[23:16];
                    if (write_mask_in[3]) ctrl_presc[15:8] <= write_value_in[31:24];
                end
                REG_DUTY_LO: duty_lo_wr <= merge_bytes(duty_lo_wr, write_value_in, write_mask_in);
                REG_DUTY_HI: duty_hi_wr <= merge_bytes(duty_hi_wr, write_value_in, write_mask_in);
                default: ;
            endcase
        end
    end

    // A wrap in the same cycle as a clearing write leaves the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_seen <= 1'b0;
        end else if (wrap) begin
            wrap_seen <= 1'b1;
        end else if (bus_wr && (reg_sel == REG_STATUS)) begin
            wrap_seen <= 1'b0;
        end
    end

`ifdef LED_PWM_SHADOW_EN
    // Active duties only change at the period boundary, or freely while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_lo_act <= '0;
            duty_hi_act <= '0;
        end else if (!ctrl_en || wrap) begin
            duty_lo_act <= duty_lo_wr;
            duty_hi_act <= duty_hi_wr;
        end
    end
`else
    assign duty_lo_act = duty_lo_wr;
    assign duty_hi_act = duty_hi_wr;
`endif

    always_comb begin
        leds_next = '0;
        for (int n = 0; n < 4; n++) begin
            leds_next[n]     = ctrl_en && (pwm_cnt < duty_lo_act[8*n +: 8]);
            leds_next[n + 4] = ctrl_en && (pwm_cnt < duty_hi_act[8*n +: 8]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds_out <= '0;
        end else begin
            leds_out <= leds_next;
        end
    end

    // Read data is OR-combined on the SoC bus, so it must be zero when unselected.
    always_comb begin
        read_value_out = '0;
        if (sel_in && read_in) begin
            case (reg_sel)
                REG_CTRL:    read_value_out = {ctrl_presc, 15'd0, ctrl_en};
                REG_DUTY_LO: read_value_out = duty_lo_wr;
                REG_DUTY_HI: read_value_out = duty_hi_wr;
                REG_STATUS:  read_value_out = {23'd0, wrap_seen, pwm_cnt};
                default:     read_value_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_led_pwm.sv
// Directed bench for led_pwm: register access, PWM duty counts, wrap flag, shadowing, reset.
// Outputs are sampled 1 time unit after the rising edge.
// The bus is zero-wait, so there is no backpressure to model.
module tb_led_pwm;

    localparam logic [31:0] A_CTRL    = 32'h0001_0000;
    localparam logic [31:0] A_DUTY_LO = 32'h0001_0004;
    localparam logic [31:0] A_DUTY_HI = 32'h0001_0008;
    localparam logic [31:0] A_STATUS  = 32'h0001_000C;

`ifdef LED_PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_in = '0;
    logic        sel_in = 1'b0;
    logic        read_in = 1'b0;
    logic [31:0] read_value_out;
    logic [3:0]  write_mask_in = '0;
    logic [31:0] write_value_in = '0;
    logic        ready_out;
    logic [7:0]  leds_out;

    int n_assert = 0;
    int n_fail   = 0;

    led_pwm dut (
        .clk            (clk),
        .reset          (reset),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .ready_out      (ready_out),
        .leds_out       (leds_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        address_in     = addr;
        write_value_in = data;
        write_mask_in  = mask;
        read_in        = 1'b0;
        sel_in         = 1'b1;
        @(posedge clk);
        #1;
        sel_in         = 1'b0;
        write_mask_in  = 4'h0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        address_in = addr;
        read_in    = 1'b1;
        sel_in     = 1'b1;
        #1;
        check(tag, read_value_out, exp);
        sel_in     = 1'b0;
        read_in    = 1'b0;
    endtask

    initial begin
        int c0, c1, c2, c3, p1, p2, nz;

        // Reset state and unselected bus behaviour
        repeat (3) @(posedge clk);
        #1;
        check("rst_leds", leds_out, 0);
        address_in = A_CTRL;
        read_in    = 1'b1;
        sel_in     = 1'b0;
        #1;
        check("nosel_rdata", read_value_out, 0);
        check("nosel_ready", ready_out, 0);
        read_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        bus_read("rst_ctrl", A_CTRL, 32'h0);
        bus_read("rst_duty_lo", A_DUTY_LO, 32'h0);
        bus_read("rst_duty_hi", A_DUTY_HI, 32'h0);
        bus_read("rst_status", A_STATUS, 32'h0);
        sel_in = 1'b1;
        #1;
        check("sel_ready", ready_out, 1);
        sel_in = 1'b0;

        // Duty 0xFF / 0x80 / 0 / 0 at PRESCALE 0
        bus_write(A_DUTY_LO, 32'h0000_80FF, 4'hF);
        bus_read("duty_lo_rb", A_DUTY_LO, 32'h0000_80FF);
        bus_write(A_CTRL, 32'h0000_0001, 4'hF);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int k = 1; k <= 255; k++) begin
            @(posedge clk);
            #1;
            c0 += int'(leds_out[0]);
            c1 += int'(leds_out[1]);
            c2 += int'(leds_out[2]);
            c3 += int'(leds_out[3]);
        end
        check("duty255_high", c0, 255);
        check("duty128_high", c1, 128);
        check("duty0_ch2", c2, 0);
        check("duty0_ch3", c3, 0);

        // Disable: outputs drop, reserved CTRL bits read 0, flag held
        bus_write(A_CTRL, 32'h0003_FFFE, 4'hF);
        @(posedge clk);
        #1;
        check("en0_leds", leds_out, 0);
        bus_read("ctrl_reserved", A_CTRL, 32'h0003_0000);
        bus_read("status_after_p0", A_STATUS, 32'h0000_0100);
        bus_write(A_STATUS, 32'h0, 4'hF);
        bus_read("status_clr", A_STATUS, 32'h0);

        // PRESCALE 3, duty 10: 40 high cycles in a 1020-cycle period
        bus_write(A_DUTY_LO, 32'h0000_000A, 4'hF);
        bus_write(A_CTRL, 32'h0003_0001, 4'hF);
        c0 = 0;
        for (int k = 1; k <= 1020; k++) begin
            @(posedge clk);
            #1;
            c0 += int'(leds_out[0]);
            if (k == 1019) bus_read("status_pre_wrap", A_STATUS, 32'h0000_00FE);
        end
        check("presc3_high", c0, 40);
        bus_read("status_wrap", A_STATUS, 32'h0000_0100);
        bus_write(A_STATUS, 32'h0, 4'hF);
        bus_read("status_clr2", A_STATUS, 32'h0);

        // Byte masking, including an all-zero mask
        bus_write(A_DUTY_HI, 32'hAABB_CCDD, 4'b0100);
        bus_read("mask_duty_hi", A_DUTY_HI, 32'h00BB_0000);
        bus_write(A_DUTY_LO, 32'hFFFF_FFFF, 4'b0000);
        bus_read("mask_zero", A_DUTY_LO, 32'h0000_000A);

        // Mid-period duty change 200 -> 20 at pwm_cnt 50; clear/wrap collision at period end
        bus_write(A_CTRL, 32'h0, 4'hF);
        bus_write(A_DUTY_LO, 32'h0000_00C8, 4'hF);
        bus_write(A_CTRL, 32'h0000_0001, 4'hF);
        p1 = 0; p2 = 0;
        for (int k = 1; k <= 510; k++) begin
            @(posedge clk);
            #1;
            if (leds_out[0]) begin
                if (k <= 255) p1++;
                else p2++;
            end
            if (k == 51) check("runt_write_edge", leds_out[0], 1);
            if (k == 52) check("runt_next_edge", leds_out[0], SHADOW ? 1 : 0);
            if (k == 50) begin
                address_in     = A_DUTY_LO;
                write_value_in = 32'd20;
                write_mask_in  = 4'hF;
                sel_in         = 1'b1;
            end
            if (k == 51) begin
                sel_in        = 1'b0;
                write_mask_in = 4'h0;
            end
            if (k == 254) begin
                address_in     = A_STATUS;
                write_value_in = 32'h0;
                write_mask_in  = 4'hF;
                sel_in         = 1'b1;
            end
            if (k == 255) begin
                sel_in        = 1'b0;
                write_mask_in = 4'h0;
                bus_read("wrap_set_wins", A_STATUS, 32'h0000_0100);
            end
        end
        check("period1_high", p1, SHADOW ? 200 : 51);
        check("period2_high", p2, 20);
        bus_read("duty_lo_new", A_DUTY_LO, 32'd20);

        // Asynchronous reset mid-period
        @(posedge clk);
        #1;
        check("pre_rst_led0", leds_out[0], 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_leds", leds_out, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        bus_read("post_rst_status", A_STATUS, 32'h0);
        bus_read("post_rst_ctrl", A_CTRL, 32'h0);
        nz = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (leds_out != 8'h00) nz++;
        end
        check("post_rst_idle", nz, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
